data_mem_model: RTL and testbench
=================================

# data_mem_model

Synthesizable multi-channel data memory that terminates the GPU's data-memory valid/ready interface. It stands in for the external data memory, so kernels such as matrix add run against RTL instead of a behavioural model. It sits directly downstream of `gpu`'s `data_mem_*` ports. A host load/peek port preloads operands and reads back results.

## Interface
Parameters:
- `ADDR_BITS`, 8: address width; array depth 2^ADDR_BITS.
- `DATA_BITS`, 8: word width.
- `CHANNELS`, 4: independent request channels.
- `LATENCY`, 2: cycles from request acceptance to `ready`; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low; idles all channels.
- `read_valid`  in  [CHANNELS-1:0]  per-channel read request.
- `read_address`  in  [CHANNELS-1:0][ADDR_BITS-1:0]  read address.
- `read_ready`  out  [CHANNELS-1:0]  read data valid.
- `read_data`  out  [CHANNELS-1:0][DATA_BITS-1:0]  read data.
- `write_valid`  in  [CHANNELS-1:0]  per-channel write request.
- `write_address`  in  [CHANNELS-1:0][ADDR_BITS-1:0]  write address.
- `write_data`  in  [CHANNELS-1:0][DATA_BITS-1:0]  write data.
- `write_ready`  out  [CHANNELS-1:0]  write committed.
- `load_enable`  in  1  host write strobe.
- `load_address`  in  ADDR_BITS  host write/peek address.
- `load_data`  in  DATA_BITS  host write data.
- `peek_data`  out  DATA_BITS  combinational `mem[load_address]`.
- `busy`  out  1  OR of all channels not IDLE.

## Operation
- Each channel runs an independent FSM with states IDLE, WAIT and RESP, plus a 4-bit down-counter.
- **IDLE:**
  - If `write_valid` is high, capture address and data, set the op to write, and go to WAIT. Write takes precedence over read when both are high.
  - Else if `read_valid` is high, capture the address, set the op to read, and go to WAIT.
  - The counter loads `LATENCY-1`.
- **WAIT:** decrement each cycle. When the counter is 0, move to RESP.
- **Entering RESP:**
  - Read: `read_data` is registered from the array and held stable through RESP.
  - Write: the array is written on that edge.
- **RESP:**
  - `read_ready` or `write_ready` is high for the captured op.
  - Stay in RESP while the corresponding valid is high.
  - When it is sampled low, return to IDLE and deassert ready on the same edge.
- Address and data inputs are ignored after capture.
- **Same-edge write collisions** to one address resolve to the lowest-index channel. The load port is lowest priority and is dropped if any channel commits to the same address on that edge.
- **Read-during-write:** a read entering RESP on the same edge as a write to the same address returns the old value.
- Array contents are not affected by reset. They are X until loaded.

## Timing
- **Reset values:** all `read_ready`, `write_ready`, `read_data` and `busy` are 0. FSMs go to IDLE and counters to 0.
- **Latency:** valid sampled at edge N → ready high after edge N+LATENCY.
  - LATENCY=1: ready rises one cycle after valid.
- **Release:** valid low sampled at edge M → ready low after edge M. The channel can accept a new request at edge M+1.
- **Throughput:** minimum LATENCY+2 cycles per access per channel. Channels are fully concurrent.
- **Reset mid-operation:** the in-flight access is abandoned. A write in WAIT is never committed. A write already committed stays.
- **Valid dropped during WAIT** (protocol violation): the access still completes. Ready asserts for one cycle, then the channel returns to IDLE.
- `load_enable` writes on the edge. The value is visible on `peek_data` and to reads entering RESP from the next edge.

## Test plan
- **Preload and single read:** LATENCY=2. Load addresses 0..15 with 0..7,0..7. Ch0 read at address 3 → `read_ready[0]` rises 2 cycles after `read_valid`, `read_data[0]`=3. Drop valid → ready low next cycle.
- **Concurrent writes:** ch0..3 write 10,11,12,13 to addresses 16..19 in the same cycle → all `write_ready` rise together. Peek addresses 16..19 returns 10..13.
- **Collision:** ch1 writes 0xAA and ch2 writes 0x55 to address 0x40 on the same edge, with `load_enable` writing 0x77 there too → peek 0x40 returns 0xAA.
- **Hold and precedence:** hold `read_valid` 5 cycles past ready → data stable throughout. Raise read and write together → write is serviced and only `write_ready` asserts.
- **Reset mid-write:** assert reset while ch0 is in WAIT for a write of 0x99 to address 5 (old value 5) → all outputs 0 immediately. Peek address 5 still returns 5.
- **Matadd traffic:** with `gpu`, 8 threads, 2 cores, LATENCY=1 and the matadd kernel → `done` asserts. Addresses 16..23 hold 0,2,4,...,14.

Source files
------------

// File: rtl/data_mem_if.sv
// Purpose: per-channel valid/ready data-memory bus between the GPU (master)
//          and the memory model (slave).
// Signals: read_valid/read_address -> read_ready/read_data,
//          write_valid/write_address/write_data -> write_ready.
interface data_mem_if #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned CHANNELS  = 4
);
    logic [CHANNELS-1:0]                read_valid;
    logic [CHANNELS-1:0][ADDR_BITS-1:0] read_address;
    logic [CHANNELS-1:0]                read_ready;
    logic [CHANNELS-1:0][DATA_BITS-1:0] read_data;
    logic [CHANNELS-1:0]                write_valid;
    logic [CHANNELS-1:0][ADDR_BITS-1:0] write_address;
    logic [CHANNELS-1:0][DATA_BITS-1:0] write_data;
    logic [CHANNELS-1:0]                write_ready;

    modport master (
        output read_valid, read_address, write_valid, write_address, write_data,
        input  read_ready, read_data, write_ready
    );

    modport slave (
        input  read_valid, read_address, write_valid, write_address, write_data,
        output read_ready, read_data, write_ready
    );
endinterface

// File: rtl/data_mem_model.sv
// Purpose: multi-channel data memory terminating the GPU data-memory bus,
//          with a host load/peek port for preloading operands and reading results.
// Ports:   clk, reset (async, active-low)
//          bus          - data_mem_if slave: per-channel read/write handshakes
//          load_enable  - host write strobe to mem[load_address]
//          load_address - host write / peek address
//          load_data    - host write data
//          peek_data    - combinational mem[load_address]
//          busy         - any channel not idle
module data_mem_model #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_if.slave            bus,
    input  logic                 load_enable,
    input  logic [ADDR_BITS-1:0] load_address,
    input  logic [DATA_BITS-1:0] load_data,
    output logic [DATA_BITS-1:0] peek_data,
    output logic                 busy
);
    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [DATA_BITS-1:0] mem [DEPTH];

    logic [CHANNELS-1:0][1:0]           state_q, state_d;
    logic [CHANNELS-1:0][CNT_W-1:0]     cnt_q, cnt_d;
    logic [CHANNELS-1:0]                op_wr_q, op_wr_d;
    logic [CHANNELS-1:0][ADDR_BITS-1:0] addr_q, addr_d;
    logic [CHANNELS-1:0][DATA_BITS-1:0] wdata_q, wdata_d;
    logic [CHANNELS-1:0]                commit_c;
    logic [CHANNELS-1:0]                rd_ready_d, wr_ready_d;
    logic                               busy_d;

    // Per-channel next-state, capture and response decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_wr_d    = op_wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        commit_c   = '0;
        rd_ready_d = '0;
        wr_ready_d = '0;
        busy_d     = 1'b0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            case (state_q[c])
                S_IDLE: begin
                    // Write wins when both valids are raised together
                    if (bus.write_valid[c]) begin
                        state_d[c] = S_WAIT;
                        op_wr_d[c] = 1'b1;
                        addr_d[c]  = bus.write_address[c];
                        wdata_d[c] = bus.write_data[c];
                        cnt_d[c]   = CNT_W'(LATENCY - 1);
                    end else if (bus.read_valid[c]) begin
                        state_d[c] = S_WAIT;
                        op_wr_d[c] = 1'b0;
                        addr_d[c]  = bus.read_address[c];
                        cnt_d[c]   = CNT_W'(LATENCY - 1);
                    end
                end
                S_WAIT: begin
                    if (cnt_q[c] == '0) begin
                        state_d[c]  = S_RESP;
                        commit_c[c] = 1'b1;
                    end else begin
                        cnt_d[c] = cnt_q[c] - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (!(op_wr_q[c] ? bus.write_valid[c] : bus.read_valid[c])) begin
                        state_d[c] = S_IDLE;
                    end
                end
                default: state_d[c] = S_IDLE;
            endcase
            rd_ready_d[c] = (state_d[c] == S_RESP) && !op_wr_d[c];
            wr_ready_d[c] = (state_d[c] == S_RESP) &&  op_wr_d[c];
            busy_d        = busy_d | (state_d[c] != S_IDLE);
        end
    end

    // Channel state and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= '0;
            cnt_q           <= '0;
            op_wr_q         <= '0;
            addr_q          <= '0;
            wdata_q         <= '0;
            bus.read_ready  <= '0;
            bus.write_ready <= '0;
            bus.read_data   <= '0;
            busy            <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            op_wr_q         <= op_wr_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            bus.read_ready  <= rd_ready_d;
            bus.write_ready <= wr_ready_d;
            busy            <= busy_d;
            // Array read sees pre-edge contents, so same-edge writes return old data
            for (int c = 0; c < int'(CHANNELS); c++) begin
                if (commit_c[c] && !op_wr_q[c]) begin
                    bus.read_data[c] <= mem[addr_q[c]];
                end
            end
        end
    end

    // Array writes: load first, then channels high-to-low so the lowest index lands last
    always_ff @(posedge clk) begin
        if (load_enable) begin
            mem[load_address] <= load_data;
        end
        for (int c = int'(CHANNELS) - 1; c >= 0; c--) begin
            if (commit_c[c] && op_wr_q[c]) begin
                mem[addr_q[c]] <= wdata_q[c];
            end
        end
    end

    assign peek_data = mem[load_address];

endmodule

// File: tb/tb_data_mem_model.sv
// Purpose: directed self-checking bench for data_mem_model (LATENCY=2, 4 channels).
module tb_data_mem_model;
    localparam int unsigned ADDR_BITS = 8;
    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned CHANNELS  = 4;
    localparam int unsigned LATENCY   = 2;

    logic                 clk;
    logic                 reset;
    logic                 load_enable;
    logic [ADDR_BITS-1:0] load_address;
    logic [DATA_BITS-1:0] load_data;
    logic [DATA_BITS-1:0] peek_data;
    logic                 busy;

    int passed;
    int total;

    data_mem_if #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .CHANNELS(CHANNELS)) bus ();

    data_mem_model #(
        .ADDR_BITS(ADDR_BITS),
        .DATA_BITS(DATA_BITS),
        .CHANNELS (CHANNELS),
        .LATENCY  (LATENCY)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .load_enable (load_enable),
        .load_address(load_address),
        .load_data   (load_data),
        .peek_data   (peek_data),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Advance to 1 time unit past the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        load_enable = 1'b0;
        load_address = '0;
        load_data = '0;
        bus.read_valid = '0;
        bus.read_address = '0;
        bus.write_valid = '0;
        bus.write_address = '0;
        bus.write_data = '0;
        step();
        step();
        total++;
        if ({bus.read_ready, bus.write_ready, busy} !== 9'h000)
            $display("FAIL reset_ready: got %h expected %h", {bus.read_ready, bus.write_ready, busy}, 9'h000);
        else passed++;
        total++;
        if (bus.read_data !== 32'h0)
            $display("FAIL reset_read_data: got %h expected %h", bus.read_data, 32'h0);
        else passed++;
        reset = 1'b1;
        step();
    endtask

    task automatic test_preload_read();
        for (int i = 0; i < 16; i++) begin
            load_enable = 1'b1;
            load_address = 8'(i);
            load_data = 8'(i % 8);
            step();
        end
        load_enable = 1'b0;
        load_address = 8'd11;
        #1;
        total++;
        if (peek_data !== 8'd3)
            $display("FAIL preload_peek: got %h expected %h", peek_data, 8'd3);
        else passed++;
        bus.read_valid[0] = 1'b1;
        bus.read_address[0] = 8'd3;
        step();
        total++;
        if ({bus.read_ready[0], busy} !== 2'b01)
            $display("FAIL read_accept: got %b expected %b", {bus.read_ready[0], busy}, 2'b01);
        else passed++;
        bus.read_address[0] = 8'd7;
        step();
        total++;
        if (bus.read_ready[0] !== 1'b0)
            $display("FAIL read_early: got %b expected %b", bus.read_ready[0], 1'b0);
        else passed++;
        step();
        total++;
        if ({bus.read_ready[0], bus.read_data[0]} !== {1'b1, 8'd3})
            $display("FAIL read_resp: got %h expected %h", {bus.read_ready[0], bus.read_data[0]}, {1'b1, 8'd3});
        else passed++;
        bus.read_valid[0] = 1'b0;
        step();
        total++;
        if ({bus.read_ready[0], busy} !== 2'b00)
            $display("FAIL read_release: got %b expected %b", {bus.read_ready[0], busy}, 2'b00);
        else passed++;
    endtask

    task automatic test_concurrent_writes();
        for (int c = 0; c < 4; c++) begin
            bus.write_address[c] = 8'(16 + c);
            bus.write_data[c] = 8'(10 + c);
        end
        bus.write_valid = 4'hF;
        step();
        step();
        total++;
        if (bus.write_ready !== 4'h0)
            $display("FAIL wr_early: got %h expected %h", bus.write_ready, 4'h0);
        else passed++;
        step();
        total++;
        if (bus.write_ready !== 4'hF)
            $display("FAIL wr_all_ready: got %h expected %h", bus.write_ready, 4'hF);
        else passed++;
        bus.write_valid = 4'h0;
        step();
        total++;
        if (bus.write_ready !== 4'h0)
            $display("FAIL wr_release: got %h expected %h", bus.write_ready, 4'h0);
        else passed++;
        for (int c = 0; c < 4; c++) begin
            load_address = 8'(16 + c);
            #1;
            total++;
            if (peek_data !== 8'(10 + c))
                $display("FAIL wr_peek_%0d: got %h expected %h", c, peek_data, 8'(10 + c));
            else passed++;
        end
    endtask

    task automatic test_collision();
        bus.write_address[1] = 8'h40;
        bus.write_data[1] = 8'hAA;
        bus.write_address[2] = 8'h40;
        bus.write_data[2] = 8'h55;
        bus.write_valid = 4'b0110;
        step();
        step();
        load_enable = 1'b1;
        load_address = 8'h40;
        load_data = 8'h77;
        step();
        total++;
        if (bus.write_ready !== 4'b0110)
            $display("FAIL coll_ready: got %b expected %b", bus.write_ready, 4'b0110);
        else passed++;
        load_enable = 1'b0;
        bus.write_valid = 4'h0;
        #1;
        total++;
        if (peek_data !== 8'hAA)
            $display("FAIL coll_peek: got %h expected %h", peek_data, 8'hAA);
        else passed++;
        step();
    endtask

    task automatic test_hold();
        bus.read_valid[0] = 1'b1;
        bus.read_address[0] = 8'd16;
        step();
        step();
        step();
        total++;
        if ({bus.read_ready[0], bus.read_data[0]} !== {1'b1, 8'd10})
            $display("FAIL hold_first: got %h expected %h", {bus.read_ready[0], bus.read_data[0]}, {1'b1, 8'd10});
        else passed++;
        bus.read_address[0] = 8'd17;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if ({bus.read_ready[0], bus.read_data[0]} !== {1'b1, 8'd10})
                $display("FAIL hold_cycle_%0d: got %h expected %h", i, {bus.read_ready[0], bus.read_data[0]}, {1'b1, 8'd10});
            else passed++;
        end
        bus.read_valid[0] = 1'b0;
        step();
        total++;
        if (bus.read_ready[0] !== 1'b0)
            $display("FAIL hold_release: got %b expected %b", bus.read_ready[0], 1'b0);
        else passed++;
    endtask

    task automatic test_precedence();
        bus.read_valid[2] = 1'b1;
        bus.read_address[2] = 8'd3;
        bus.write_valid[2] = 1'b1;
        bus.write_address[2] = 8'h50;
        bus.write_data[2] = 8'h5A;
        step();
        step();
        step();
        total++;
        if ({bus.read_ready, bus.write_ready} !== 8'h04)
            $display("FAIL prec_ready: got %h expected %h", {bus.read_ready, bus.write_ready}, 8'h04);
        else passed++;
        bus.read_valid[2] = 1'b0;
        bus.write_valid[2] = 1'b0;
        step();
        total++;
        if ({bus.read_ready, bus.write_ready} !== 8'h00)
            $display("FAIL prec_release: got %h expected %h", {bus.read_ready, bus.write_ready}, 8'h00);
        else passed++;
        load_address = 8'h50;
        #1;
        total++;
        if (peek_data !== 8'h5A)
            $display("FAIL prec_peek: got %h expected %h", peek_data, 8'h5A);
        else passed++;
    endtask

    task automatic test_valid_drop();
        bus.read_valid[3] = 1'b1;
        bus.read_address[3] = 8'd5;
        step();
        bus.read_valid[3] = 1'b0;
        step();
        total++;
        if (bus.read_ready[3] !== 1'b0)
            $display("FAIL drop_early: got %b expected %b", bus.read_ready[3], 1'b0);
        else passed++;
        step();
        total++;
        if ({bus.read_ready[3], bus.read_data[3]} !== {1'b1, 8'd5})
            $display("FAIL drop_resp: got %h expected %h", {bus.read_ready[3], bus.read_data[3]}, {1'b1, 8'd5});
        else passed++;
        step();
        total++;
        if ({bus.read_ready[3], busy} !== 2'b00)
            $display("FAIL drop_release: got %b expected %b", {bus.read_ready[3], busy}, 2'b00);
        else passed++;
    endtask

    task automatic test_read_during_write();
        bus.write_valid[0] = 1'b1;
        bus.write_address[0] = 8'd7;
        bus.write_data[0] = 8'h21;
        bus.read_valid[1] = 1'b1;
        bus.read_address[1] = 8'd7;
        step();
        step();
        step();
        total++;
        if ({bus.write_ready[0], bus.read_ready[1], bus.read_data[1]} !== {2'b11, 8'd7})
            $display("FAIL rdw_old: got %h expected %h", {bus.write_ready[0], bus.read_ready[1], bus.read_data[1]}, {2'b11, 8'd7});
        else passed++;
        bus.write_valid[0] = 1'b0;
        bus.read_valid[1] = 1'b0;
        step();
        load_address = 8'd7;
        #1;
        total++;
        if (peek_data !== 8'h21)
            $display("FAIL rdw_peek: got %h expected %h", peek_data, 8'h21);
        else passed++;
    endtask

    task automatic test_reset_mid_write();
        bus.write_valid[0] = 1'b1;
        bus.write_address[0] = 8'd5;
        bus.write_data[0] = 8'h99;
        step();
        total++;
        if (busy !== 1'b1)
            $display("FAIL rst_busy_before: got %b expected %b", busy, 1'b1);
        else passed++;
        reset = 1'b0;
        #1;
        total++;
        if ({bus.read_ready, bus.write_ready, busy} !== 9'h000)
            $display("FAIL rst_mid_ready: got %h expected %h", {bus.read_ready, bus.write_ready, busy}, 9'h000);
        else passed++;
        total++;
        if (bus.read_data !== 32'h0)
            $display("FAIL rst_mid_data: got %h expected %h", bus.read_data, 32'h0);
        else passed++;
        bus.write_valid[0] = 1'b0;
        step();
        step();
        reset = 1'b1;
        load_address = 8'd5;
        #1;
        total++;
        if (peek_data !== 8'd5)
            $display("FAIL rst_mid_peek: got %h expected %h", peek_data, 8'd5);
        else passed++;
        step();
    endtask

    initial begin
        passed = 0;
        total = 0;
        test_reset();
        test_preload_read();
        test_concurrent_writes();
        test_collision();
        test_hold();
        test_precedence();
        test_valid_drop();
        test_read_during_write();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
